// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide unit: shift-add MUL/MULHU, restoring DIVU/REMU.
// One operation in flight; result leaves as a single-cycle register-file write request.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dst,
  output logic             busy,
  output logic             we,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [AW-1:0]      dst_q;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   result;

  // opnd_q holds the multiplicand for MUL/MULHU and the divisor for DIVU/REMU.
  // acc is {upper, lower}: product for multiply, {remainder, quotient} for divide.
  always_comb begin
    accept  = start && (state != RUN);
    last    = (cnt == CW'(WIDTH));

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
    div_next = diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Low half serves MUL and DIVU, high half serves MULHU and REMU.
    result   = op_q[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
  end

  // RUN spends cnt=0..WIDTH-1 iterating and one more cycle (cnt=WIDTH)
  // registering the write request, so busy covers WIDTH+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      opnd_q <= '0;
      dst_q  <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      we     <= 1'b0;
      wa     <= '0;
      wd     <= '0;
    end else begin
      we <= 1'b0;
      if (accept) begin
        op_q   <= op;
        opnd_q <= op[1] ? b : a;
        acc    <= op[1] ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
        dst_q  <= dst;
        cnt    <= '0;
        busy   <= 1'b1;
        state  <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (last) begin
              we    <= 1'b1;
              wa    <= dst_q;
              wd    <= result;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              acc <= op_q[1] ? div_next : mul_next;
              cnt <= cnt + CW'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
